// File: rtl/prefetch.sv
// prefetch: writer end of the instruction-byte FIFO.
// Fetches 16-bit words at CS:IP over the memory bus, splits them into bytes
// (low byte first) and pushes one byte per cycle into the FIFO. A
// load_new_ip strobe flushes the FIFO and restarts fetching at new_cs:new_ip.
// A bus cycle already in flight is always completed before the restart.
//
// Ports:
//   clk, reset_n               core clock, async active-low reset
//   load_new_ip, new_cs/new_ip flush + restart strobe and target address
//   fifo_wr_en/fifo_wr_data    byte write into the FIFO
//   fifo_full                  FIFO back-pressure
//   fifo_reset                 one-cycle FIFO flush pulse
//   mem_access/mem_ack         bus request / completion handshake
//   mem_address                word address (physical[19:1])
//   mem_data                   read word, [7:0] even byte, [15:8] odd byte
module prefetch (
  input  logic        clk,
  input  logic        reset_n,
  input  logic        load_new_ip,
  input  logic [15:0] new_cs,
  input  logic [15:0] new_ip,
  output logic        fifo_wr_en,
  output logic [7:0]  fifo_wr_data,
  input  logic        fifo_full,
  output logic        fifo_reset,
  output logic        mem_access,
  input  logic        mem_ack,
  output logic [18:0] mem_address,
  input  logic [15:0] mem_data
);

  typedef enum logic {FETCH, PUSH} state_t;

  state_t      state, state_d;
  logic [15:0] cs, cs_d;
  logic [15:0] fetch_ip, ip_d;
  logic [15:0] hold, hold_d;
  logic        valid_lo, lo_d;
  logic        valid_hi, hi_d;
  logic        abort, abort_d;
  logic        access_d;
  logic [18:0] addr_d;
  logic [18:0] word_addr;

  // physical[19:1] == cs*8 + ip[15:1] (mod 2^19): the segment base is even,
  // so ip[0] never carries into the word address.
  assign word_addr = {cs, 3'b000} + {4'b0000, fetch_ip[15:1]};

  assign fifo_wr_en   = (state == PUSH) & (valid_lo | valid_hi) & ~fifo_full & ~load_new_ip;
  assign fifo_wr_data = valid_lo ? hold[7:0] : hold[15:8];
  // Qualified with reset so every output sits at its idle value while in reset.
  assign fifo_reset   = load_new_ip & reset_n;

  always_comb begin
    state_d  = state;
    cs_d     = cs;
    ip_d     = fetch_ip;
    hold_d   = hold;
    lo_d     = valid_lo;
    hi_d     = valid_hi;
    abort_d  = abort;
    access_d = mem_access;
    addr_d   = mem_address;

    if (load_new_ip) begin
      cs_d    = new_cs;
      ip_d    = new_ip;
      hold_d  = 16'h0000;
      lo_d    = 1'b0;
      hi_d    = 1'b0;
      state_d = FETCH;
      if (mem_access && !mem_ack) begin
        // Bus cycle cannot be cancelled: keep request and old address,
        // throw the data away when it arrives.
        abort_d = 1'b1;
      end else begin
        abort_d  = 1'b0;
        access_d = 1'b0;
      end
    end else begin
      case (state)
        FETCH: begin
          if (abort) begin
            if (mem_ack) begin
              abort_d  = 1'b0;
              access_d = 1'b0;
            end
          end else if (!mem_access) begin
            access_d = 1'b1;
            addr_d   = word_addr;
          end else if (mem_ack) begin
            hold_d   = mem_data;
            hi_d     = 1'b1;
            lo_d     = ~fetch_ip[0];   // odd IP: low byte precedes IP
            ip_d     = fetch_ip + (fetch_ip[0] ? 16'd1 : 16'd2);
            access_d = 1'b0;
            state_d  = PUSH;
          end
        end
        PUSH: begin
          if (fifo_wr_en) begin
            if (valid_lo) begin
              lo_d = 1'b0;
              if (!valid_hi) state_d = FETCH;
            end else begin
              hi_d    = 1'b0;
              state_d = FETCH;
            end
          end else if (!valid_lo && !valid_hi) begin
            state_d = FETCH;
          end
        end
        default: state_d = FETCH;
      endcase
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state       <= FETCH;
      cs          <= 16'hFFFF;
      fetch_ip    <= 16'h0000;
      hold        <= 16'h0000;
      valid_lo    <= 1'b0;
      valid_hi    <= 1'b0;
      abort       <= 1'b0;
      mem_access  <= 1'b0;
      mem_address <= 19'h7FFF8;
    end else begin
      state       <= state_d;
      cs          <= cs_d;
      fetch_ip    <= ip_d;
      hold        <= hold_d;
      valid_lo    <= lo_d;
      valid_hi    <= hi_d;
      abort       <= abort_d;
      mem_access  <= access_d;
      mem_address <= addr_d;
    end
  end

endmodule

// File: tb/tb_prefetch.sv
// Bench for prefetch: a bus responder with programmable or random latency,
// and a byte-stream reference model. The model tracks the next CS:IP to be
// fetched and a queue of bytes owed to the FIFO; every cycle it checks the
// FIFO strobe/data, flush pulse, request address and address stability.
module tb_prefetch;
  logic        clk = 1'b0;
  logic        reset_n = 1'b0;
  logic        load_new_ip = 1'b0;
  logic [15:0] new_cs = '0, new_ip = '0;
  logic        fifo_full = 1'b0;
  logic        mem_ack = 1'b0;
  logic [15:0] mem_data = '0;
  logic        fifo_wr_en, fifo_reset, mem_access;
  logic [7:0]  fifo_wr_data;
  logic [18:0] mem_address;

  prefetch dut (
    .clk(clk), .reset_n(reset_n), .load_new_ip(load_new_ip),
    .new_cs(new_cs), .new_ip(new_ip),
    .fifo_wr_en(fifo_wr_en), .fifo_wr_data(fifo_wr_data),
    .fifo_full(fifo_full), .fifo_reset(fifo_reset),
    .mem_access(mem_access), .mem_ack(mem_ack),
    .mem_address(mem_address), .mem_data(mem_data)
  );

  always #5 clk = ~clk;

  int checks = 0, failures = 0;

  // reference model state
  logic [7:0]  exp_q[$];
  int          m_cs, m_ip;
  bit          discard, in_req, acked;
  logic [18:0] held_addr;
  logic [7:0]  last_byte;
  int          writes = 0, idle = 0;
  // bus responder knobs
  int          req_age = 0, ack_lat = 2;
  bit          rand_lat = 0, use_dir = 1;
  logic [15:0] dir_data = 16'h1234;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0h exp=%0h t=%0t", tag, got, exp, $time);
    end
  endtask

  function automatic int word_of(input int cs, input int ip);
    return ((cs * 16 + ip) % 32'h100000) / 2;
  endfunction

  task automatic reset_model();
    exp_q.delete();
    m_cs = 16'hFFFF; m_ip = 0;
    discard = 0; in_req = 0; acked = 0;
    req_age = 0; idle = 0;
  endtask

  // One clock cycle: drive inputs just after the edge, sample mid-cycle.
  task automatic step(input bit ld, input logic [15:0] ncs, input logic [15:0] nip, input bit full);
    @(posedge clk); #1;
    load_new_ip = ld; new_cs = ncs; new_ip = nip; fifo_full = full;
    mem_ack = 1'b0; acked = 0;
    if (mem_access) begin
      if (req_age == 0 && rand_lat) ack_lat = $urandom_range(0, 3);
      if (req_age >= ack_lat) begin
        mem_ack  = 1'b1;
        mem_data = use_dir ? dir_data : 16'($urandom);
      end
    end
    #3;
    chk("fifo_reset", fifo_reset, ld);
    chk("wr_en", fifo_wr_en, (exp_q.size() != 0) && !full && !ld);
    if (fifo_wr_en && exp_q.size() != 0) begin
      last_byte = fifo_wr_data;
      writes++;
      chk("wr_data", fifo_wr_data, exp_q.pop_front());
    end
    if (mem_access) begin
      idle = 0;
      chk("req_while_bytes_owed", exp_q.size(), 0);
      if (!in_req) begin
        in_req = 1; held_addr = mem_address;
        if (!discard) chk("req_addr", mem_address, word_of(m_cs, m_ip));
      end else begin
        chk("addr_stable", mem_address, held_addr);
      end
    end else if (exp_q.size() == 0 && !ld) begin
      idle++;
      if (idle > 2) chk("req_gap", idle, 2);
    end else begin
      idle = 0;
    end
    // model update for the coming edge
    if (mem_access && mem_ack) begin
      if (!discard && !ld) begin
        if (m_ip % 2 == 0) exp_q.push_back(mem_data[7:0]);
        exp_q.push_back(mem_data[15:8]);
        m_ip = (m_ip + ((m_ip % 2) ? 1 : 2)) % 65536;
        acked = 1;
      end
      in_req = 0; discard = 0; req_age = 0;
    end else if (mem_access) begin
      req_age++;
    end
    if (ld) begin
      exp_q.delete();
      m_cs = ncs; m_ip = nip;
      if (mem_access && !mem_ack) discard = 1;
    end
  endtask

  task automatic wait_ack(input bit full);
    bit got = 0;
    for (int i = 0; i < 30; i++) begin
      step(0, 16'h0, 16'h0, full);
      if (acked) begin got = 1; break; end
    end
    if (!got) chk("ack_timeout", got, 1);
  endtask

  task automatic wait_req();
    bit got = 0;
    for (int i = 0; i < 30; i++) begin
      step(0, 16'h0, 16'h0, 1'b0);
      if (in_req) begin got = 1; break; end
    end
    if (!got) chk("req_timeout", got, 1);
  endtask

  initial begin
    int stall = 0;
    reset_model();
    #12;
    chk("rst_access", mem_access, 0);
    chk("rst_wr_en", fifo_wr_en, 0);
    chk("rst_fifo_reset", fifo_reset, 0);
    chk("rst_addr", mem_address, 19'h7FFF8);
    reset_n = 1'b1;

    // boot fetch at FFFF:0000, acked on the 3rd request cycle
    wait_req();
    chk("t1_addr", mem_address, 19'h7FFF8);
    wait_ack(0);
    step(0, 16'h0, 16'h0, 0); chk("t1_b0", last_byte, 8'h34);
    step(0, 16'h0, 16'h0, 0); chk("t1_b1", last_byte, 8'h12);
    wait_req();
    chk("t1_next", mem_address, 19'h7FFF9);

    // restart at odd IP 0000:0101
    dir_data = 16'hABCD;
    step(1, 16'h0000, 16'h0101, 0);
    wait_ack(0);
    step(0, 16'h0, 16'h0, 0); chk("t2_byte", last_byte, 8'hAB);
    wait_req();
    chk("t2_next", mem_address, 19'h00081);

    // FIFO full for 5 cycles after the ack
    dir_data = 16'h5566;
    wait_ack(0);
    repeat (5) step(0, 16'h0, 16'h0, 1);
    step(0, 16'h0, 16'h0, 0); chk("t3_b0", last_byte, 8'h66);
    step(0, 16'h0, 16'h0, 0); chk("t3_b1", last_byte, 8'h55);

    // flush while a bus cycle is pending; second strobe wins
    ack_lat = 5; dir_data = 16'hDEAD;
    wait_req();
    step(1, 16'h2000, 16'h0010, 0);
    step(0, 16'h0, 16'h0, 0);
    step(1, 16'h1000, 16'h0000, 0);
    ack_lat = 1;
    wait_req();
    chk("t4_next", mem_address, 19'h08000);
    wait_ack(0);
    step(0, 16'h0, 16'h0, 0); chk("t4_b0", last_byte, 8'hAD);

    // IP FFFF: high byte only, then wrap to 0000
    dir_data = 16'h77EE;
    step(1, 16'h0000, 16'hFFFF, 0);
    wait_req();
    chk("t5_addr", mem_address, 19'h07FFF);
    wait_ack(0);
    step(0, 16'h0, 16'h0, 0); chk("t5_byte", last_byte, 8'h77);
    wait_req();
    chk("t5_wrap", mem_address, 19'h00000);

    // reset asserted mid-PUSH with bytes still held
    dir_data = 16'h1234;
    wait_ack(0);
    @(posedge clk); #2;
    reset_n = 1'b0; mem_ack = 1'b0;
    #1;
    chk("t6_wr_en", fifo_wr_en, 0);
    chk("t6_access", mem_access, 0);
    chk("t6_fifo_reset", fifo_reset, 0);
    chk("t6_addr", mem_address, 19'h7FFF8);
    repeat (2) @(posedge clk);
    @(negedge clk);
    reset_model();
    reset_n = 1'b1;
    wait_req();
    chk("t6_first_req", mem_address, 19'h7FFF8);

    // randomized traffic
    rand_lat = 1; use_dir = 0;
    for (int i = 0; i < 4000; i++) begin
      bit ld;
      logic [15:0] ncs, nip;
      ld  = ($urandom_range(0, 24) == 0);
      ncs = ($urandom_range(0, 5) == 0) ? 16'hFFFF : 16'($urandom);
      nip = ($urandom_range(0, 5) == 0) ? 16'hFFFF : 16'($urandom);
      if (stall == 0 && $urandom_range(0, 20) == 0) stall = $urandom_range(1, 12);
      if (stall > 0) stall--;
      step(ld, ncs, nip, (stall > 0) || ($urandom_range(0, 3) == 0));
    end
    chk("bytes_seen", writes > 200, 1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/prefetch.md
Name: prefetch

Overview:
- Writer end of the instruction-byte FIFO that the ModR/M decoder and immediate reader consume.
- Fetches 16-bit words from the memory bus at CS:IP and splits them into bytes, low byte first.
- Pushes one byte per cycle into the FIFO, and stalls whenever the FIFO reports full.
- On a control-flow change, flushes the FIFO and restarts fetching from the new CS:IP. Any bus cycle already in flight is completed before the restart.

Parameters:
- None.

Ports:
- clk  in  1  core clock; all state changes on the rising edge.
- reset_n  in  1  asynchronous, active-low reset.
- load_new_ip  in  1  one-cycle strobe: flush and restart at new_cs:new_ip.
- new_cs  in  16  code segment for the restart.
- new_ip  in  16  instruction pointer for the restart.
- fifo_wr_en  out  1  FIFO write strobe; one byte per asserted cycle.
- fifo_wr_data  out  8  byte to write.
- fifo_full  in  1  FIFO cannot accept a write this cycle.
- fifo_reset  out  1  one-cycle FIFO flush pulse.
- mem_access  out  1  bus request; held high until mem_ack.
- mem_ack  in  1  bus completion; mem_data is valid this cycle.
- mem_address  out  19  word address, physical[19:1].
- mem_data  in  16  read word; [7:0] is at the even byte, [15:8] at the odd byte.

Behaviour:
- State:
  - cs, fetch_ip (16 bits each).
  - 16-bit holding register with valid_lo and valid_hi flags.
  - abort flag.
  - FSM with states FETCH and PUSH.
- Reset (reset_n low, asynchronous):
  - cs=16'hFFFF, fetch_ip=16'h0000, state=FETCH.
  - Holding register empty; abort=0.
  - fifo_wr_en=0, fifo_reset=0, mem_access=0.
  - mem_address=19'h7FFF8 (physical 20'hFFFF0).
- Addressing:
  - physical = ({cs,4'b0} + {4'b0,fetch_ip}) mod 2^20.
  - mem_address = physical[19:1].
- FETCH:
  - mem_access asserts the cycle after entering FETCH, or the first cycle after reset_n deasserts.
  - mem_access and mem_address stay stable until mem_ack.
  - On mem_ack:
    - Latch mem_data.
    - valid_hi=1. valid_lo = ~fetch_ip[0], so an odd IP discards the low byte.
    - fetch_ip += (fetch_ip[0] ? 1 : 2), wrapping modulo 2^16 within the segment; cs is unchanged.
    - Go to PUSH. mem_access is low the next cycle.
- PUSH:
  - fifo_wr_en = (valid_lo|valid_hi) & ~fifo_full & ~load_new_ip, combinational.
  - fifo_wr_data = valid_lo ? hold[7:0] : hold[15:8].
  - Each write clears the flag it consumed.
  - When both flags are clear, go to FETCH.
  - Minimum 2 cycles per aligned word; fifo_full inserts wait cycles with data held.
- Flush (load_new_ip=1, any state):
  - fifo_reset=1 that same cycle, combinational and exactly one cycle.
  - No fifo_wr_en that cycle.
  - cs<=new_cs, fetch_ip<=new_ip, holding register cleared.
  - If no bus cycle is outstanding, or mem_ack is high that same cycle: go to FETCH; any acked data is discarded.
  - If mem_access is high without mem_ack: set abort, keep mem_access and the old mem_address until mem_ack, discard that data, clear abort, then enter FETCH at the new address.
  - A second load_new_ip while abort is set replaces the restart address; the last strobe wins.
- Boundaries:
  - IP 16'hFFFF: fetch word at cs:FFFE, push high byte only, next fetch_ip=16'h0000.
  - Physical wrap: cs=FFFF, ip=0010 gives physical 20'h00000.
  - fifo_full held indefinitely: hold data, no loss, no new bus request.
- No FIFO writes ever occur between a flush and the first ack after it.

Test Plan:
- Reset release, mem_data=16'h1234 acked on the 3rd request cycle, fifo_full=0 -> mem_address=19'h7FFF8; bytes 8'h34 then 8'h12 on consecutive cycles; next request at 19'h7FFF9.
- load_new_ip with cs=0000, ip=0101, mem_data=16'hABCD -> mem_address=19'h00080; only 8'hAB written; next request at 19'h00081.
- fifo_full=1 for 5 cycles after an ack of 16'h5566 -> no writes and no mem_access during the stall; then 8'h66, 8'h55; no byte dropped or duplicated.
- load_new_ip (cs=1000, ip=0000) while mem_access is pending and acked 3 cycles later with 16'hDEAD -> fifo_reset pulses once; old address held until ack; 16'hDEAD discarded; next request at 19'h08000.
- cs=0000, ip=FFFF, mem_data=16'h77EE -> one write of 8'h77; next mem_address=19'h00000.
- reset_n asserted mid-PUSH with valid_hi=1 -> outputs at reset values immediately; after release the first request is at 19'h7FFF8 and the pending byte is never written.
